// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int PC_W_DEF       = 10;
   localparam int START_ADDR_DEF = 0;
   localparam int CNT_W          = 16;

endpackage

// File: rtl/pc_next.sv
// Next program-counter selection while running: stall > halt > absolute > relative > increment.
module pc_next #(
   parameter int PC_W = 10
) (
   input  logic [PC_W-1:0] pc,
   input  logic            stall,
   input  logic            halt,
   input  logic            branch_abs,
   input  logic            branch_rel,
   input  logic [7:0]      target,
   output logic [PC_W-1:0] pc_nxt
);

   // Widen to at least 8 bits so narrow PCs simply truncate the extended target.
   localparam int EW = (PC_W > 8) ? PC_W : 8;

   logic [EW-1:0] tgt_zx;
   logic [EW-1:0] tgt_sx;

   assign tgt_zx = EW'(target);
   assign tgt_sx = EW'($signed(target));

   always_comb begin
      pc_nxt = pc;
      if (stall || halt) begin
         pc_nxt = pc;
      end else if (branch_abs) begin
         pc_nxt = tgt_zx[PC_W-1:0];
      end else if (branch_rel) begin
         pc_nxt = pc + tgt_sx[PC_W-1:0];
      end else begin
         pc_nxt = pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/pc_ctrl.sv
// Program sequencer: IDLE/RUN/DONE handshake around a program counter and run-cycle counter.
//
// state | meaning
// IDLE  | PC parked at START_ADDR, waiting for start
// RUN   | fetching; PC advances per pc_next, cycle count increments
// DONE  | halted; PC and count frozen until host ack
module pc_ctrl
   import pc_pkg::*;
#(
   parameter int PC_W       = PC_W_DEF,
   parameter int START_ADDR = START_ADDR_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             ack,
   input  logic             stall,
   input  logic             halt,
   input  logic             branch_abs,
   input  logic             branch_rel,
   input  logic [7:0]       target,
   output logic [PC_W-1:0]  prog_ctr,
   output logic             running,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   state_t          state;
   logic [PC_W-1:0] pc_nxt;

   pc_next #(.PC_W(PC_W)) u_pc_next (
      .pc         (prog_ctr),
      .stall      (stall),
      .halt       (halt),
      .branch_abs (branch_abs),
      .branch_rel (branch_rel),
      .target     (target),
      .pc_nxt     (pc_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         prog_ctr  <= START_PC;
         cycle_cnt <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               prog_ctr <= START_PC;
               if (start) begin
                  state     <= RUN;
                  cycle_cnt <= '0;
                  running   <= 1'b1;
               end
            end
            RUN: begin
               prog_ctr <= pc_nxt;
               if (cycle_cnt != {CNT_W{1'b1}}) begin
                  cycle_cnt <= cycle_cnt + CNT_W'(1);
               end
               // Stall outranks halt, so a stalled halt stays in RUN.
               if (halt && !stall) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               if (ack) begin
                  state    <= IDLE;
                  prog_ctr <= START_PC;
                  done     <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               prog_ctr <= START_PC;
               running  <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: driver queues expected post-edge state, monitor pops and compares.
module tb_pc_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start, ack, stall, halt, branch_abs, branch_rel;
   logic [7:0]  target;
   logic [9:0]  prog_ctr;
   logic        running, done;
   logic [15:0] cycle_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [9:0]  pc;
      logic        run;
      logic        dn;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   pc_ctrl #(.PC_W(10), .START_ADDR(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ack        (ack),
      .stall      (stall),
      .halt       (halt),
      .branch_abs (branch_abs),
      .branch_rel (branch_rel),
      .target     (target),
      .prog_ctr   (prog_ctr),
      .running    (running),
      .done       (done),
      .cycle_cnt  (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
      end
   endtask

   task automatic cmp_all(input exp_t e);
      cmp(e.name, "prog_ctr", 16'(prog_ctr), 16'(e.pc));
      cmp(e.name, "running", 16'(running), 16'(e.run));
      cmp(e.name, "done", 16'(done), 16'(e.dn));
      cmp(e.name, "cycle_cnt", cycle_cnt, e.cnt);
   endtask

   task automatic step(input string nm, input logic s, input logic a, input logic st,
                       input logic h, input logic ba, input logic br, input logic [7:0] t,
                       input logic [9:0] epc, input logic er, input logic ed, input logic [15:0] ec);
      exp_t e;
      @(negedge clk);
      start = s; ack = a; stall = st; halt = h; branch_abs = ba; branch_rel = br; target = t;
      e.name = nm; e.pc = epc; e.run = er; e.dn = ed; e.cnt = ec;
      exp_q.push_back(e);
   endtask

   task automatic clear_inputs();
      start = 0; ack = 0; stall = 0; halt = 0; branch_abs = 0; branch_rel = 0; target = 8'h00;
   endtask

   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         cmp_all(mon_e);
      end
   end

   task automatic drain();
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      exp_t r;
      clear_inputs();
      rst_n = 1'b0;
      #1;
      r.name = "reset"; r.pc = 0; r.run = 0; r.dn = 0; r.cnt = 0;
      cmp_all(r);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      //     name        s a st h ba br target  pc   run dn cnt
      step("start",      1,0,0, 0,0, 0, 8'h00,  0,   1, 0, 0);
      step("inc1",       0,0,0, 0,0, 0, 8'h00,  1,   1, 0, 1);
      step("inc2",       0,1,0, 0,0, 0, 8'h00,  2,   1, 0, 2);
      step("inc3",       1,0,0, 0,0, 0, 8'h00,  3,   1, 0, 3);
      step("inc4",       0,0,0, 0,0, 0, 8'h00,  4,   1, 0, 4);
      step("inc5",       0,0,0, 0,0, 0, 8'h00,  5,   1, 0, 5);
      step("abs20",      0,0,0, 0,1, 0, 8'd20,  20,  1, 0, 6);
      step("rel_m10",    0,0,0, 0,0, 1, 8'hF6,  10,  1, 0, 7);
      step("abs20b",     0,0,0, 0,1, 0, 8'd20,  20,  1, 0, 8);
      step("rel_p14",    0,0,0, 0,0, 1, 8'h0E,  34,  1, 0, 9);
      step("abs_rel",    0,0,0, 0,1, 1, 8'd91,  91,  1, 0, 10);
      step("stall_br",   0,0,1, 0,1, 1, 8'd50,  91,  1, 0, 11);
      step("stall_halt", 0,0,1, 1,0, 0, 8'h00,  91,  1, 0, 12);
      step("abs2",       0,0,0, 0,1, 0, 8'd2,   2,   1, 0, 13);
      step("rel_m3wrap", 0,0,0, 0,0, 1, 8'hFD,  1023,1, 0, 14);
      step("inc_wrap",   0,0,0, 0,0, 0, 8'h00,  0,   1, 0, 15);
      step("abs2b",      0,0,0, 0,1, 0, 8'd2,   2,   1, 0, 16);
      step("rel_m2",     0,0,0, 0,0, 1, 8'hFE,  0,   1, 0, 17);
      step("abs30",      0,0,0, 0,1, 0, 8'd30,  30,  1, 0, 18);
      step("halt",       0,0,0, 1,0, 0, 8'h00,  30,  0, 1, 19);
      step("done_start", 1,0,0, 0,1, 0, 8'd77,  30,  0, 1, 19);
      step("done_hold",  0,0,1, 1,0, 1, 8'h05,  30,  0, 1, 19);
      step("ack",        0,1,0, 0,0, 0, 8'h00,  0,   0, 0, 19);
      step("idle_noise", 0,1,0, 1,1, 1, 8'd40,  0,   0, 0, 19);
      step("restart",    1,0,0, 0,0, 0, 8'h00,  0,   1, 0, 0);
      step("abs60",      0,0,0, 0,1, 0, 8'd60,  60,  1, 0, 1);
      drain();

      rst_n = 1'b0;
      #1;
      r.name = "reset_midrun"; r.pc = 0; r.run = 0; r.dn = 0; r.cnt = 0;
      cmp_all(r);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst",   1,0,0, 0,0, 0, 8'h00,  0,   1, 0, 0);
      step("post_inc",   0,0,0, 0,0, 0, 8'h00,  1,   1, 0, 1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
